clk_div_bank: RTL and testbench

//   Bank of N_CH independent clock dividers sharing one clock. Each channel's divisor is

---
 rtl/clk_div_bank.sv | 93 +++++++++
 tb/tb_clk_div_bank.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of runtime-programmable clock dividers with shared sync
// Divisor writes land in a shadow and reach the counter only at a point where no half-period is cut short.
module clk_div_bank #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 24,
  parameter int DEFAULT_DIV = 1,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [N_CH-1:0]   cfg_pend,
  output logic [N_CH-1:0]   div_clk,
  output logic [N_CH-1:0]   tick
);

  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CH_W:0]    N_CH_EXT = (CH_W + 1)'(N_CH);

  logic [CNT_W-1:0] cnt [N_CH];
  logic [CNT_W-1:0] act [N_CH];
  logic [CNT_W-1:0] shd [N_CH];

  logic             ch_ok;
  logic [N_CH-1:0]  wr_hit;
  logic [N_CH-1:0]  term;
  logic [N_CH-1:0]  apply;

  assign ch_ok = ({1'b0, cfg_ch} < N_CH_EXT);

  // apply marks edges where swapping the divisor cannot shorten or stretch a half-period
  always_comb begin
    wr_hit = '0;
    term   = '0;
    apply  = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i] = cfg_we && ch_ok && (cfg_ch == CH_W'(i));
      term[i]   = (cnt[i] >= act[i]);
      apply[i]  = sync || !en[i] || term[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
        act[i] <= DEF_DIV;
        shd[i] <= DEF_DIV;
      end
      cfg_pend <= '0;
      div_clk  <= '0;
      tick     <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sync) begin
          cnt[i]     <= '0;
          div_clk[i] <= 1'b0;
          tick[i]    <= 1'b0;
        end else if (en[i]) begin
          if (term[i]) begin
            cnt[i]     <= '0;
            div_clk[i] <= ~div_clk[i];
            tick[i]    <= 1'b1;
          end else begin
            cnt[i]  <= cnt[i] + CNT_W'(1);
            tick[i] <= 1'b0;
          end
        end else begin
          tick[i] <= 1'b0;
        end

        // A write on an apply edge bypasses the shadow so the newest value wins
        if (wr_hit[i]) begin
          shd[i] <= cfg_div;
          if (apply[i]) begin
            act[i]      <= cfg_div;
            cfg_pend[i] <= 1'b0;
          end else begin
            cfg_pend[i] <= 1'b1;
          end
        end else if (apply[i] && cfg_pend[i]) begin
          act[i]      <= shd[i];
          cfg_pend[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - directed self-checking bench for clk_div_bank
// A second 3-channel instance provides an unused channel index for the out-of-range write case.
module tb_clk_div_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync;
  logic [3:0]  en;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [23:0] cfg_div;
  logic [3:0]  cfg_pend;
  logic [3:0]  div_clk;
  logic [3:0]  tick;

  logic        sync_b;
  logic [2:0]  en_b;
  logic        cfg_we_b;
  logic [1:0]  cfg_ch_b;
  logic [7:0]  cfg_div_b;
  logic [2:0]  cfg_pend_b;
  logic [2:0]  div_clk_b;
  logic [2:0]  tick_b;

  int tests = 0;
  int fails = 0;

  clk_div_bank #(.N_CH(4), .CNT_W(24), .DEFAULT_DIV(1)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_pend(cfg_pend), .div_clk(div_clk), .tick(tick)
  );

  clk_div_bank #(.N_CH(3), .CNT_W(8), .DEFAULT_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .sync(sync_b), .cfg_we(cfg_we_b), .cfg_ch(cfg_ch_b),
    .cfg_div(cfg_div_b), .cfg_pend(cfg_pend_b), .div_clk(div_clk_b), .tick(tick_b)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; sync = 1'b0; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    sync_b = 1'b0; en_b = '0; cfg_we_b = 1'b0; cfg_ch_b = '0; cfg_div_b = '0;
    step;
    step;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; sync = 1'b0; en = 4'hF; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 24'd7;
    sync_b = 1'b0; en_b = 3'h7; cfg_we_b = 1'b0; cfg_ch_b = '0; cfg_div_b = '0;
    step;
    step;
    tests++;
    if (div_clk !== 4'h0 || tick !== 4'h0 || cfg_pend !== 4'h0) begin
      fails++;
      $display("FAIL reset_a got div=%h tick=%h pend=%h exp all 0", div_clk, tick, cfg_pend);
    end
    tests++;
    if (div_clk_b !== 3'h0 || tick_b !== 3'h0 || cfg_pend_b !== 3'h0) begin
      fails++;
      $display("FAIL reset_b got div=%h tick=%h pend=%h exp all 0", div_clk_b, tick_b, cfg_pend_b);
    end
  endtask

  task automatic test_default_div;
    logic [3:0] ed, et;
    do_reset;
    en = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      step;
      ed = ((k / 2) % 2 == 1) ? 4'hF : 4'h0;
      et = (k % 2 == 0) ? 4'hF : 4'h0;
      tests++;
      if (div_clk !== ed || tick !== et) begin
        fails++;
        $display("FAIL default_div k=%0d got div=%h tick=%h exp div=%h tick=%h", k, div_clk, tick, ed, et);
      end
    end
  endtask

  task automatic test_div_zero;
    logic ed;
    do_reset;
    en = 4'h1;
    step;
    step;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 24'd0;
    step;
    cfg_we = 1'b0;
    tests++;
    if (cfg_pend !== 4'h1 || div_clk !== 4'h1 || tick !== 4'h0) begin
      fails++;
      $display("FAIL div_zero_pend got pend=%h div=%h tick=%h exp pend=1 div=1 tick=0", cfg_pend, div_clk, tick);
    end
    for (int j = 4; j <= 10; j++) begin
      step;
      ed = (j % 2 == 1);
      tests++;
      if (div_clk[0] !== ed || tick[0] !== 1'b1 || cfg_pend !== 4'h0) begin
        fails++;
        $display("FAIL div_zero j=%0d got div0=%b tick0=%b pend=%h exp div0=%b tick0=1 pend=0", j, div_clk[0], tick[0], cfg_pend, ed);
      end
    end
  endtask

  task automatic test_mid_write;
    logic [3:0] ed, et;
    do_reset;
    en = 4'h2;
    step;
    step;
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 24'd4;
    step;
    cfg_we = 1'b0;
    tests++;
    if (cfg_pend !== 4'h2 || div_clk !== 4'h2) begin
      fails++;
      $display("FAIL mid_write_pend got pend=%h div=%h exp pend=2 div=2", cfg_pend, div_clk);
    end
    for (int j = 4; j <= 14; j++) begin
      step;
      ed = (j >= 9 && j <= 13) ? 4'h2 : 4'h0;
      et = (j == 4 || j == 9 || j == 14) ? 4'h2 : 4'h0;
      tests++;
      if (div_clk !== ed || tick !== et || cfg_pend !== 4'h0) begin
        fails++;
        $display("FAIL mid_write j=%0d got div=%h tick=%h pend=%h exp div=%h tick=%h pend=0", j, div_clk, tick, cfg_pend, ed, et);
      end
    end
  endtask

  task automatic test_disabled_write;
    logic [3:0] ed, et;
    do_reset;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 24'd9;
    step;
    cfg_we = 1'b0;
    tests++;
    if (cfg_pend !== 4'h0) begin
      fails++;
      $display("FAIL idle_write_pend got pend=%h exp 0", cfg_pend);
    end
    en = 4'h4;
    repeat (5) step;
    tests++;
    if (div_clk !== 4'h0 || tick !== 4'h0) begin
      fails++;
      $display("FAIL d9_no_toggle got div=%h tick=%h exp 0 0", div_clk, tick);
    end
    en = 4'h0;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 24'd2;
    step;
    cfg_we = 1'b0;
    tests++;
    if (cfg_pend !== 4'h0 || div_clk !== 4'h0 || tick !== 4'h0) begin
      fails++;
      $display("FAIL en_off_write got pend=%h div=%h tick=%h exp 0 0 0", cfg_pend, div_clk, tick);
    end
    step;
    en = 4'h4;
    for (int r = 1; r <= 7; r++) begin
      step;
      ed = (((r - 1) / 3) % 2 == 0) ? 4'h4 : 4'h0;
      et = ((r - 1) % 3 == 0) ? 4'h4 : 4'h0;
      tests++;
      if (div_clk !== ed || tick !== et) begin
        fails++;
        $display("FAIL reenable r=%0d got div=%h tick=%h exp div=%h tick=%h", r, div_clk, tick, ed, et);
      end
    end
  endtask

  task automatic test_sync;
    logic [3:0] ed, et;
    do_reset;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 24'd3;
    step;
    cfg_ch = 2'd1; cfg_div = 24'd5;
    step;
    cfg_we = 1'b0;
    en = 4'h7;
    repeat (10) step;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 24'd7;
    step;
    cfg_we = 1'b0;
    tests++;
    if (cfg_pend !== 4'h4) begin
      fails++;
      $display("FAIL sync_pre_pend got pend=%h exp 4", cfg_pend);
    end
    sync = 1'b1;
    step;
    sync = 1'b0;
    tests++;
    if (div_clk !== 4'h0 || tick !== 4'h0 || cfg_pend !== 4'h0) begin
      fails++;
      $display("FAIL sync_clear got div=%h tick=%h pend=%h exp 0 0 0", div_clk, tick, cfg_pend);
    end
    for (int j = 1; j <= 16; j++) begin
      step;
      ed = {1'b0, ((j / 8) % 2 == 1), ((j / 6) % 2 == 1), ((j / 4) % 2 == 1)};
      et = {1'b0, (j % 8 == 0), (j % 6 == 0), (j % 4 == 0)};
      tests++;
      if (div_clk !== ed || tick !== et) begin
        fails++;
        $display("FAIL sync_align j=%0d got div=%h tick=%h exp div=%h tick=%h", j, div_clk, tick, ed, et);
      end
    end
  endtask

  task automatic test_bad_channel;
    logic [2:0] ed;
    do_reset;
    en_b = 3'h7;
    cfg_we_b = 1'b1; cfg_ch_b = 2'd3; cfg_div_b = 8'd0;
    step;
    cfg_we_b = 1'b0;
    tests++;
    if (cfg_pend_b !== 3'h0 || div_clk_b !== 3'h0) begin
      fails++;
      $display("FAIL bad_ch got pend=%h div=%h exp 0 0", cfg_pend_b, div_clk_b);
    end
    for (int k = 2; k <= 5; k++) begin
      step;
      ed = ((k / 2) % 2 == 1) ? 3'h7 : 3'h0;
      tests++;
      if (div_clk_b !== ed || cfg_pend_b !== 3'h0) begin
        fails++;
        $display("FAIL bad_ch_run k=%0d got div=%h pend=%h exp div=%h pend=0", k, div_clk_b, cfg_pend_b, ed);
      end
    end
  endtask

  task automatic test_write_at_term;
    logic ed, et;
    do_reset;
    en = 4'h1;
    step;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 24'd2;
    step;
    cfg_we = 1'b0;
    tests++;
    if (cfg_pend !== 4'h0 || div_clk !== 4'h1 || tick !== 4'h1) begin
      fails++;
      $display("FAIL term_write got pend=%h div=%h tick=%h exp 0 1 1", cfg_pend, div_clk, tick);
    end
    for (int j = 3; j <= 5; j++) begin
      step;
      ed = (j != 5);
      et = (j == 5);
      tests++;
      if (div_clk[0] !== ed || tick[0] !== et) begin
        fails++;
        $display("FAIL term_write_run j=%0d got div0=%b tick0=%b exp div0=%b tick0=%b", j, div_clk[0], tick[0], ed, et);
      end
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    en = 4'hF;
    step;
    step;
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 24'd5;
    step;
    cfg_we = 1'b0;
    tests++;
    if (div_clk !== 4'hF || cfg_pend !== 4'h8) begin
      fails++;
      $display("FAIL async_pre got div=%h pend=%h exp div=f pend=8", div_clk, cfg_pend);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (div_clk !== 4'h0 || tick !== 4'h0 || cfg_pend !== 4'h0) begin
      fails++;
      $display("FAIL async_rst got div=%h tick=%h pend=%h exp 0 0 0", div_clk, tick, cfg_pend);
    end
    step;
    rst = 1'b0;
    en = 4'h0;
  endtask

  initial begin
    test_reset;
    test_default_div;
    test_div_zero;
    test_mid_write;
    test_disabled_write;
    test_sync;
    test_bad_channel;
    test_write_at_term;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
